hack_fetch: RTL and testbench
=============================

# hack_fetch

Instruction fetch stage for the Hack datapath. Holds the program counter, issues one read at a time to instruction ROM over a req/ack handshake, and presents each fetched word to the decode stage over a valid/ready handshake. The jump target is the A-register value selected through the 16-bit mux path and arrives on `jump_addr`. All pending or held work is discarded when a jump redirects fetch.

## Interface

Parameters:
- `ADDR_W`, default 15: ROM address width (32K words).
- `DATA_W`, default 16: instruction width.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `imem_req`  out  1  read request to ROM.
- `imem_addr`  out  ADDR_W  read address; stable while `imem_req` is high.
- `imem_ack`  in  1  ROM has returned data this cycle.
- `imem_rdata`  in  DATA_W  read data; valid only when `imem_ack` is high.
- `jump`  in  1  one-cycle redirect strobe.
- `jump_addr`  in  ADDR_W  redirect target; sampled when `jump` is high.
- `instr_valid`  out  1  `instr` and `instr_pc` are valid.
- `instr_ready`  in  1  decode stage accepts the instruction this cycle.
- `instr`  out  DATA_W  fetched instruction.
- `instr_pc`  out  ADDR_W  address the instruction was fetched from.

## Operation

- **Reset values:**
  - `pc` = `RESET_PC`; `state` = IDLE; `discard` = 0.
  - `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - `instr_valid` = 0, `instr` = 0, `instr_pc` = 0.
- **States:**
  - IDLE: moves to REQ on the next edge; only entered from reset.
  - REQ: `imem_req` = 1 and `imem_addr` = `pc`, both held until ack.
    - On `imem_ack` with `discard` = 0: capture `imem_rdata` into `instr` and `imem_addr` into `instr_pc`; set `instr_valid`; `pc` ← `imem_addr`+1; go to HOLD.
    - On `imem_ack` with `discard` = 1: drop the data; clear `discard`; stay in REQ at the new `pc`.
  - HOLD: `imem_req` = 0 and `instr_valid` = 1.
    - On `instr_valid` & `instr_ready`: clear `instr_valid`; go to REQ.
- **PC arithmetic:** `pc`+1 is taken modulo 2^ADDR_W, so 0x7FFF wraps to 0x0000.
- **Jump handling:** `pc` ← `jump_addr` in every state.
  - REQ without ack: the in-flight request is not retracted. `imem_addr` stays unchanged until ack; set `discard`.
  - REQ with ack in the same cycle: drop the data (no `instr_valid`). Next cycle is REQ at `jump_addr`.
  - HOLD without `instr_ready`: flush the held instruction (`instr_valid` → 0 next cycle); go to REQ.
  - HOLD with a handshake in the same cycle: the instruction counts as consumed. Go to REQ at `jump_addr`.
  - IDLE: the first fetch goes to `jump_addr`.
  - A second jump before the discarded ack arrives: last target wins; `discard` stays set.
- **Reset mid-operation:** outputs drop to reset values asynchronously. A ROM ack arriving during or after reset is ignored until the next REQ.

## Timing

- Fetch latency: with ack in the same cycle as req, `instr_valid` rises on the edge after ack. That is one cycle from REQ entry.
- Best-case throughput is one instruction per 2 cycles (REQ, HOLD) with zero-wait ROM and `instr_ready` held high.
- Outputs are registered. The only exception is `imem_addr`, which is `pc` driven combinationally from a register.
- `instr`, `instr_pc` and `instr_valid` must not change while `instr_valid` = 1 and `instr_ready` = 0. The only exception is a jump flush.

## Structure

- **Package `hack_pkg`:**
  - `fetch_state_t` enum: IDLE, REQ, HOLD.
  - Localparams `HACK_ADDR_W` = 15 and `HACK_DATA_W` = 16.
- **Sub-module `pc_counter`:**
  - ADDR_W register with async reset to `RESET_PC`.
  - Inputs `load`/`load_val` and `inc`; `load` has priority over `inc`; wraps on increment.
- Top level holds the state machine, the `discard` flag and the output registers.

## Test plan

- **Reset and linear fetch:** reset, then zero-wait ROM returning `addr`^0x1000 with `instr_ready` = 1.
  - Outputs (`instr_pc`, `instr`) are (0, 0x1000), (1, 0x1001), (2, 0x1002), each valid one cycle, one per 2 cycles.
- **Backpressure:** `instr_ready` = 0 for 5 cycles with `instr_valid` high.
  - `instr` and `instr_pc` stay stable and `imem_req` stays 0.
  - After `ready` rises, exactly one transfer occurs.
- **Jump during outstanding request:** ack delay 3; jump to 0x0123 one cycle after req at 0x0004.
  - `imem_addr` stays 0x0004 until ack and that data is never presented.
  - The next request is 0x0123 and the next `instr_pc` is 0x0123.
- **Jump while holding:** `instr_valid` high at `instr_pc` 0x0010, `instr_ready` = 0, jump to 0x0040.
  - `instr_valid` drops next cycle and the next `instr_pc` is 0x0040.
- **Wrap-around:** jump to 0x7FFF, zero-wait ROM.
  - Consecutive `instr_pc` are 0x7FFF then 0x0000.
- **Async reset mid-fetch:** assert `reset` between edges while in HOLD.
  - `instr_valid` and `imem_req` go to 0 without waiting for a clock edge.
  - After release, the first request is `RESET_PC`.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared types and widths for the Hack datapath front end.
package hack_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: load beats increment, increment wraps at 2^ADDR_W.
// Latency: new value visible the cycle after load/inc; no backpressure of its own.
module pc_counter #(
  parameter int                ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/hack_fetch.sv
// Hack fetch stage: one ROM read in flight, result held for decode until accepted.
// Latency: instr_valid the edge after imem_ack; decode stall freezes the held word, jump flushes it.
module hack_fetch
  import hack_pkg::*;
#(
  parameter int                ADDR_W   = HACK_ADDR_W,
  parameter int                DATA_W   = HACK_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic              discard;
  logic              discard_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] hold_addr;
  logic              pc_inc;
  logic              capture;
  logic              valid_clr;
  logic              hold_load;

  pc_counter #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .load    (jump),
    .load_val(jump_addr),
    .inc     (pc_inc),
    .pc      (pc)
  );

  // pc already points at the jump target while the stale read is still in flight.
  assign imem_addr = discard ? hold_addr : pc;
  assign imem_req  = (state == REQ);

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    pc_inc      = 1'b0;
    capture     = 1'b0;
    valid_clr   = 1'b0;
    hold_load   = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          discard_nxt = 1'b0;
          if (!jump && !discard) begin
            capture   = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = HOLD;
          end
        end else if (jump) begin
          discard_nxt = 1'b1;
          hold_load   = !discard;
        end
      end
      HOLD: begin
        if (jump || (instr_valid && instr_ready)) begin
          valid_clr = 1'b1;
          state_nxt = REQ;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      discard   <= 1'b0;
      hold_addr <= RESET_PC;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
      if (hold_load) begin
        hold_addr <= pc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else if (capture) begin
      instr_valid <= 1'b1;
      instr       <= imem_rdata;
      instr_pc    <= imem_addr;
    end else if (valid_clr) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hack_fetch.sv
// Bench for hack_fetch: ROM model returning addr^0x1000, next-pc model, directed scenarios.
module tb_hack_fetch;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          jump;
  logic [AW-1:0] jump_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;

  hack_fetch #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RESET_PC('0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM: ack after rom_delay extra cycles of a held request.
  int rom_delay = 0;
  int rom_cnt   = 0;
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset || !imem_req) begin
        imem_ack = 1'b0;
        rom_cnt  = 0;
      end else begin
        if (imem_ack) rom_cnt = 0;
        imem_ack   = (rom_cnt >= rom_delay);
        imem_rdata = {1'b0, imem_addr} ^ 16'h1000;
        if (!imem_ack) rom_cnt++;
      end
    end
  end

  // Model: the next presented instruction must come from exp_pc.
  logic [AW-1:0] exp_pc;
  logic          p_valid, p_ready, p_jmp, p_req, p_ack;
  logic [AW-1:0] p_pc, p_jaddr, p_addr;
  logic [DW-1:0] p_dat;
  logic [AW-1:0] xfer_pc[$];
  logic [DW-1:0] xfer_dat[$];
  int            xfer_cyc[$];
  logic [AW-1:0] ack_log[$];
  logic [AW-1:0] req_log[$];
  int            cyc = 0;

  initial begin
    exp_pc  = '0;
    p_valid = 0; p_ready = 0; p_jmp = 0; p_req = 0; p_ack = 0;
    p_pc = '0; p_jaddr = '0; p_addr = '0; p_dat = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        exp_pc  = '0;
        p_valid = 0; p_ready = 0; p_jmp = 0; p_req = 0; p_ack = 0;
      end else begin
        if (p_valid && p_ready) begin
          xfer_pc.push_back(p_pc);
          xfer_dat.push_back(p_dat);
          xfer_cyc.push_back(cyc);
          exp_pc = p_pc + AW'(1);
        end
        if (p_jmp) exp_pc = p_jaddr;
        if (p_ack) ack_log.push_back(p_addr);
        if (p_valid && !p_ready && !p_jmp) begin
          check("stall valid", instr_valid, 1);
          check("stall pc", instr_pc, p_pc);
          check("stall instr", instr, p_dat);
        end
        if (p_valid && (p_ready || p_jmp)) check("valid drop", instr_valid, 0);
        if (instr_valid && !p_valid) begin
          check("present pc", instr_pc, exp_pc);
          check("present instr", instr, {1'b0, exp_pc} ^ 16'h1000);
        end
        if (imem_req && p_req && !p_ack) check("req addr stable", imem_addr, p_addr);
        if (imem_req && (!p_req || p_ack)) begin
          check("new req addr", imem_addr, exp_pc);
          req_log.push_back(imem_addr);
        end
        check("req/valid exclusive", imem_req & instr_valid, 0);
        p_valid = instr_valid; p_ready = instr_ready; p_jmp = jump;
        p_jaddr = jump_addr;   p_req = imem_req;      p_ack = imem_ack;
        p_addr  = imem_addr;   p_pc = instr_pc;       p_dat = instr;
      end
    end
  end

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < budget);
    check(name, instr_valid, 1);
  endtask

  task automatic wait_xfers(input int cnt, input int budget, input string name);
    int n = 0;
    while (xfer_pc.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, xfer_pc.size() >= cnt, 1);
  endtask

  task automatic wait_req(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req && n < budget);
    check(name, imem_req, 1);
  endtask

  logic [AW-1:0] held_pc;
  logic [DW-1:0] held_dat;
  int            n0;

  initial begin
    reset = 1'b1; jump = 1'b0; jump_addr = '0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset instr_valid", instr_valid, 0);
    check("reset instr", instr, 0);
    check("reset instr_pc", instr_pc, 0);
    check("reset imem_req", imem_req, 0);
    check("reset imem_addr", imem_addr, 0);
    reset = 1'b0;
    instr_ready = 1'b1;

    // Linear fetch, zero-wait ROM.
    wait_xfers(3, 30, "linear count");
    if (xfer_pc.size() >= 3) begin
      check("linear pc0", xfer_pc[0], 15'h0000);
      check("linear dat0", xfer_dat[0], 16'h1000);
      check("linear pc1", xfer_pc[1], 15'h0001);
      check("linear dat1", xfer_dat[1], 16'h1001);
      check("linear pc2", xfer_pc[2], 15'h0002);
      check("linear dat2", xfer_dat[2], 16'h1002);
      check("linear spacing", xfer_cyc[2] - xfer_cyc[1], 2);
    end

    // Backpressure for 5 cycles, then a single-cycle ready pulse.
    @(posedge clk); #1 instr_ready = 1'b0;
    wait_valid(20, "bp valid");
    held_pc  = instr_pc;
    held_dat = instr;
    n0       = xfer_pc.size();
    check("bp held pc", held_pc, 15'h0003);
    repeat (5) begin
      @(negedge clk);
      check("bp pc", instr_pc, held_pc);
      check("bp instr", instr, held_dat);
      check("bp req low", imem_req, 0);
    end
    @(posedge clk); #1 instr_ready = 1'b1; rom_delay = 3;
    @(posedge clk); #1 instr_ready = 1'b0;

    // Jump one cycle after the request at 0x0004 goes out.
    wait_req(10, "jreq seen");
    check("jreq addr", imem_addr, 15'h0004);
    @(posedge clk); #1 jump = 1'b1; jump_addr = 15'h0123;
    @(posedge clk); #1 jump = 1'b0;
    repeat (4) @(negedge clk);
    check("bp one transfer", xfer_pc.size(), n0 + 1);
    instr_ready = 1'b1;
    wait_xfers(n0 + 2, 40, "jreq count");
    if (xfer_pc.size() >= n0 + 2 && ack_log.size() >= 2) begin
      check("jreq xfer pc", xfer_pc[n0+1], 15'h0123);
      check("jreq xfer dat", xfer_dat[n0+1], 16'h1123);
      check("jreq stale ack", ack_log[ack_log.size()-2], 15'h0004);
      check("jreq new ack", ack_log[ack_log.size()-1], 15'h0123);
    end
    @(posedge clk); #1 instr_ready = 1'b0; rom_delay = 0;

    // Jump while holding with decode stalled.
    @(posedge clk); #1 jump = 1'b1; jump_addr = 15'h0010;
    @(posedge clk); #1 jump = 1'b0;
    wait_valid(30, "hold valid");
    check("hold pc", instr_pc, 15'h0010);
    n0 = xfer_pc.size();
    @(posedge clk); #1 jump = 1'b1; jump_addr = 15'h0040;
    @(posedge clk); #1 jump = 1'b0;
    @(negedge clk);
    check("hold flush", instr_valid, 0);
    wait_valid(20, "hold refetch");
    check("hold new pc", instr_pc, 15'h0040);
    check("hold new instr", instr, 16'h1040);
    check("hold no xfer", xfer_pc.size(), n0);

    // Jump to 0x7FFF together with a handshake on the held 0x0040.
    @(posedge clk); #1 jump = 1'b1; jump_addr = 15'h7FFF; instr_ready = 1'b1;
    @(posedge clk); #1 jump = 1'b0;
    wait_xfers(n0 + 3, 30, "wrap count");
    if (xfer_pc.size() >= n0 + 3) begin
      check("wrap consumed", xfer_pc[n0], 15'h0040);
      check("wrap pc top", xfer_pc[n0+1], 15'h7FFF);
      check("wrap pc zero", xfer_pc[n0+2], 15'h0000);
      check("wrap dat zero", xfer_dat[n0+2], 16'h1000);
    end
    @(posedge clk); #1 instr_ready = 1'b0;

    // Asynchronous reset between edges while holding.
    wait_valid(20, "arst valid");
    @(negedge clk);
    check("arst pre valid", instr_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("arst valid", instr_valid, 0);
    check("arst req", imem_req, 0);
    check("arst instr_pc", instr_pc, 0);
    check("arst imem_addr", imem_addr, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_req(10, "arst req seen");
    check("arst first addr", imem_addr, 15'h0000);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
